// File: rtl/decode_hazard_ctrl.sv
// Decode-stage interlock: shadows in-flight destination registers, stalls on
// unbypassable RAW hazards, selects Ps6 write-through, counts stalls, checks writeback.
module decode_hazard_ctrl #(
    parameter int PIPE_DEPTH  = 4,
    parameter int KILL_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1_addr,
    input  logic             dec_rs1_used,
    input  logic [4:0]       dec_rs2_addr,
    input  logic             dec_rs2_used,
    input  logic [4:0]       dec_rd_addr,
    input  logic             dec_rd_we,
    input  logic             pipe_hold,
    input  logic             flush,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    output logic             dec_stall,
    output logic             rs1_forward,
    output logic             rs2_forward,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             wb_mismatch
);

    localparam int unsigned DEPTH = PIPE_DEPTH;
    localparam int unsigned KILL  = KILL_STAGES;

    logic [PIPE_DEPTH-1:0] sh_v;
    logic [PIPE_DEPTH-1:0] sh_we;
    logic [4:0]            sh_rd [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] live;

    logic src1_req, src2_req;
    logic src1_hit_old, src2_hit_old;
    logic src1_hit_wb, src2_hit_wb;
    logic wb_bad;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live[i] = sh_v[i] & sh_we[i] & (sh_rd[i] != 5'd0);
        end
    end

    assign src1_req = dec_rs1_used & (dec_rs1_addr != 5'd0);
    assign src2_req = dec_rs2_used & (dec_rs2_addr != 5'd0);

    always_comb begin
        src1_hit_old = 1'b0;
        src2_hit_old = 1'b0;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (live[i] && (sh_rd[i] == dec_rs1_addr)) src1_hit_old = src1_req;
            if (live[i] && (sh_rd[i] == dec_rs2_addr)) src2_hit_old = src2_req;
        end
        src1_hit_wb = src1_req & live[DEPTH-1] & (sh_rd[DEPTH-1] == dec_rs1_addr);
        src2_hit_wb = src2_req & live[DEPTH-1] & (sh_rd[DEPTH-1] == dec_rs2_addr);
    end

    assign dec_stall   = dec_valid & (src1_hit_old | src2_hit_old | pipe_hold) & ~flush;
    // A younger in-flight producer overrides the Ps6 write-through.
    assign rs1_forward = dec_valid & src1_hit_wb & ~src1_hit_old;
    assign rs2_forward = dec_valid & src2_hit_wb & ~src2_hit_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_v <= '0;
        end else if (flush) begin
            if (pipe_hold) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (i < KILL) sh_v[i] <= 1'b0;
                end
            end else begin
                // Killed entries still advance, so they arrive invalid one slot older.
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    sh_v[i]  <= sh_v[i-1] & (i > KILL);
                    sh_we[i] <= sh_we[i-1];
                    sh_rd[i] <= sh_rd[i-1];
                end
                sh_v[0]  <= 1'b0;
                sh_we[0] <= 1'b0;
                sh_rd[0] <= 5'd0;
            end
        end else if (!pipe_hold) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sh_v[i]  <= sh_v[i-1];
                sh_we[i] <= sh_we[i-1];
                sh_rd[i] <= sh_rd[i-1];
            end
            sh_v[0]  <= dec_valid & ~dec_stall;
            sh_we[0] <= dec_rd_we;
            sh_rd[0] <= dec_rd_addr;
        end
    end

    assign wb_bad = ~live[DEPTH-1] | (sh_rd[DEPTH-1] != wb_rd) | (wb_rd == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_mismatch <= 1'b0;
        end else if (wb_we && wb_bad) begin
            wb_mismatch <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (dec_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: vector table, directed corner
// sequences and randomized traffic against an in-bench reference model.
module tb_decode_hazard_ctrl;

    localparam int PD = 4;
    localparam int KS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       dec_valid;
    logic [4:0] dec_rs1_addr;
    logic       dec_rs1_used;
    logic [4:0] dec_rs2_addr;
    logic       dec_rs2_used;
    logic [4:0] dec_rd_addr;
    logic       dec_rd_we;
    logic       pipe_hold;
    logic       flush;
    logic       wb_we;
    logic [4:0] wb_rd;
    logic        dec_stall, rs1_forward, rs2_forward, wb_mismatch;
    logic [15:0] stall_cycles;

    logic        s_valid, s_hold;
    logic        s_stall, s_f1, s_f2, s_mm;
    logic [3:0]  s_cnt;

    decode_hazard_ctrl #(.PIPE_DEPTH(PD), .KILL_STAGES(KS), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs1_used(dec_rs1_used),
        .dec_rs2_addr(dec_rs2_addr), .dec_rs2_used(dec_rs2_used),
        .dec_rd_addr(dec_rd_addr), .dec_rd_we(dec_rd_we),
        .pipe_hold(pipe_hold), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
        .dec_stall(dec_stall), .rs1_forward(rs1_forward), .rs2_forward(rs2_forward),
        .stall_cycles(stall_cycles), .wb_mismatch(wb_mismatch)
    );

    decode_hazard_ctrl #(.PIPE_DEPTH(PD), .KILL_STAGES(KS), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .dec_valid(s_valid),
        .dec_rs1_addr(5'd0), .dec_rs1_used(1'b0),
        .dec_rs2_addr(5'd0), .dec_rs2_used(1'b0),
        .dec_rd_addr(5'd0), .dec_rd_we(1'b0),
        .pipe_hold(s_hold), .flush(1'b0), .wb_we(1'b0), .wb_rd(5'd0),
        .dec_stall(s_stall), .rs1_forward(s_f1), .rs2_forward(s_f2),
        .stall_cycles(s_cnt), .wb_mismatch(s_mm)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: list of in-flight instructions by age slot.
    logic       m_v  [PD] = '{default: 1'b0};
    logic       m_we [PD] = '{default: 1'b0};
    logic [4:0] m_rd [PD] = '{default: 5'd0};
    int         m_cnt = 0;
    int         m_mm  = 0;

    function automatic int youngest(logic [4:0] a, logic used);
        if (!used || a == 5'd0) return -1;
        for (int i = 0; i < PD; i++)
            if (m_v[i] && m_we[i] && m_rd[i] == a) return i;
        return -1;
    endfunction

    function automatic int m_stall();
        int y1 = youngest(dec_rs1_addr, dec_rs1_used);
        int y2 = youngest(dec_rs2_addr, dec_rs2_used);
        bit haz = (y1 >= 0 && y1 < PD-1) || (y2 >= 0 && y2 < PD-1);
        return (dec_valid && (haz || pipe_hold) && !flush) ? 1 : 0;
    endfunction

    function automatic int m_fwd1();
        return (dec_valid && youngest(dec_rs1_addr, dec_rs1_used) == PD-1) ? 1 : 0;
    endfunction

    function automatic int m_fwd2();
        return (dec_valid && youngest(dec_rs2_addr, dec_rs2_used) == PD-1) ? 1 : 0;
    endfunction

    task automatic model_update();
        int st = m_stall();
        if (rst) begin
            for (int i = 0; i < PD; i++) m_v[i] = 1'b0;
            m_cnt = 0;
            m_mm  = 0;
        end else begin
            if (wb_we && (!(m_v[PD-1] && m_we[PD-1] && m_rd[PD-1] != 5'd0)
                          || m_rd[PD-1] != wb_rd || wb_rd == 5'd0)) m_mm = 1;
            if (st == 1 && m_cnt < 65535) m_cnt++;
            if (flush)
                for (int i = 0; i < KS; i++) m_v[i] = 1'b0;
            if (!pipe_hold) begin
                for (int i = PD-1; i > 0; i--) begin
                    m_v[i] = m_v[i-1]; m_we[i] = m_we[i-1]; m_rd[i] = m_rd[i-1];
                end
                m_v[0]  = dec_valid && !flush && st == 0;
                m_we[0] = dec_rd_we;
                m_rd[0] = dec_rd_addr;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Waits to the falling edge, then compares; a value of -1 skips that field.
    task automatic look(string tag, int st, int f1, int f2, int cnt, int mm);
        @(negedge clk);
        if (st  >= 0) chk({tag, ".stall"}, int'(dec_stall), st);
        if (f1  >= 0) chk({tag, ".fwd1"},  int'(rs1_forward), f1);
        if (f2  >= 0) chk({tag, ".fwd2"},  int'(rs2_forward), f2);
        if (cnt >= 0) chk({tag, ".cnt"},   int'(stall_cycles), cnt);
        if (mm  >= 0) chk({tag, ".mm"},    int'(wb_mismatch), mm);
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_rs1_addr = 5'd0; dec_rs1_used = 1'b0;
        dec_rs2_addr = 5'd0; dec_rs2_used = 1'b0; dec_rd_addr = 5'd0;
        dec_rd_we = 1'b0; pipe_hold = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_rd = 5'd0;
    endtask

    task automatic ins(logic v, logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                       logic [4:0] rd, logic we);
        dec_valid = v; dec_rs1_addr = r1; dec_rs1_used = u1;
        dec_rs2_addr = r2; dec_rs2_used = u2; dec_rd_addr = rd; dec_rd_we = we;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic v; logic [4:0] r1; logic u1; logic [4:0] r2; logic u2;
        logic [4:0] rd; logic we; logic hold; logic fl; logic wbwe; logic [4:0] wbrd;
        int st; int f1; int f2; int cnt; int mm;
    } vec_t;

    vec_t tv [6];

    initial begin
        // addi x5 ; add x6,x5,x1 back to back
        tv[0] = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0, 0, 0, 0, 0};
        tv[1] = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1, 0, 0, 0, 0};
        tv[2] = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1, 0, 0, 1, 0};
        tv[3] = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1, 0, 0, 2, 0};
        tv[4] = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 0, 1, 0, 3, 0};
        tv[5] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 0, 0, 0, 3, 0};

        s_valid = 1'b0; s_hold = 1'b0;
        idle();
        rst = 1'b1;
        tick();
        // stall follows pipe_hold even while reset is asserted
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        pipe_hold = 1'b1;
        look("rst_hold", 1, 0, 0, -1, -1);
        tick();
        rst = 1'b0;
        idle();
        look("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            ins(tv[i].v, tv[i].r1, tv[i].u1, tv[i].r2, tv[i].u2, tv[i].rd, tv[i].we);
            pipe_hold = tv[i].hold; flush = tv[i].fl;
            wb_we = tv[i].wbwe; wb_rd = tv[i].wbrd;
            look($sformatf("tbl%0d", i), tv[i].st, tv[i].f1, tv[i].f2, tv[i].cnt, tv[i].mm);
            tick();
        end

        // x0 never hits; writeback to x0 is an error that sticks until reset
        do_reset();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        look("x0_prod", 0, 0, 0, -1, 0);
        tick();
        ins(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1);
        look("x0_cons", 0, 0, 0, 0, 0);
        tick();
        idle(); wb_we = 1'b1; wb_rd = 5'd0;
        tick();
        idle();
        look("wb0_set", -1, -1, -1, -1, 1);
        tick(); tick();
        look("wb0_stick", -1, -1, -1, -1, 1);
        do_reset();
        look("wb0_clr", -1, -1, -1, -1, 0);

        // two producers of x7, two cycles apart: younger one governs
        do_reset();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); tick();
        idle(); tick();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); tick();
        ins(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
        look("dup_c3", 1, 0, 0, 0, -1); tick();
        wb_we = 1'b1; wb_rd = 5'd7;
        look("dup_c4", 1, 0, 0, 1, 0); tick();
        wb_we = 1'b0;
        look("dup_c5", 1, 0, 0, 2, -1); tick();
        wb_we = 1'b1; wb_rd = 5'd7;
        look("dup_c6", 0, 1, 0, 3, 0); tick();
        idle();
        look("dup_end", 0, 0, 0, 3, 0);

        // flush kills producer; flush with hazard never stalls
        do_reset();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); tick();
        ins(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); flush = 1'b1;
        look("fl_haz", 0, 0, 0, 0, -1); tick();
        flush = 1'b0;
        look("fl_gone", 0, 0, 0, 0, -1); tick();
        // flush+hold leaves entry 2 alone and does not shift
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1); tick();
        idle(); tick(); tick();
        pipe_hold = 1'b1; flush = 1'b1; tick();
        idle();
        ins(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        look("flh_e2", 1, 0, 0, 0, -1); tick();
        look("flh_e3", 0, 1, 0, 1, -1); tick();

        // pipe_hold freezes the shadow for 5 cycles
        do_reset();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1); tick();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1); pipe_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            look($sformatf("hold%0d", i), 1, 0, 0, i, -1);
            tick();
        end
        pipe_hold = 1'b0;
        ins(1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0);
        look("hold_e0", 1, 0, 0, 5, -1); tick(); tick(); tick();
        look("hold_e3", 0, 0, 1, 8, -1); tick();

        // reset while a consumer of x3 is stalled
        do_reset();
        ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1); tick();
        ins(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
        look("rs_stall", 1, 0, 0, 0, -1); tick();
        rst = 1'b1;
        look("rs_during", 1, 0, 0, 1, -1); tick();
        rst = 1'b0;
        look("rs_after", 0, 0, 0, 0, 0); tick();
        ins(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        look("rs_issued", 1, 0, 0, 0, -1); tick();

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            dec_valid    = ($urandom_range(0, 3) != 0);
            dec_rs1_addr = 5'($urandom_range(0, 7));
            dec_rs1_used = ($urandom_range(0, 3) != 0);
            dec_rs2_addr = 5'($urandom_range(0, 7));
            dec_rs2_used = ($urandom_range(0, 1) != 0);
            dec_rd_addr  = 5'($urandom_range(0, 7));
            dec_rd_we    = ($urandom_range(0, 3) != 0);
            pipe_hold    = ($urandom_range(0, 9) < 2);
            flush        = ($urandom_range(0, 9) == 0);
            rst          = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) != 0) begin
                wb_we = m_v[PD-1] && m_we[PD-1] && m_rd[PD-1] != 5'd0;
                wb_rd = m_rd[PD-1];
            end else begin
                wb_we = 1'b1;
                wb_rd = 5'($urandom_range(0, 7));
            end
            look("rnd", m_stall(), m_fwd1(), m_fwd2(), m_cnt, m_mm);
            tick();
        end
        rst = 1'b0;
        idle();

        // 4-bit counter saturates at 15
        do_reset();
        s_valid = 1'b1; s_hold = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        @(negedge clk);
        chk("sat14", int'(s_cnt), 14);
        tick(); tick(); tick();
        @(negedge clk);
        chk("sat15", int'(s_cnt), 15);
        chk("sat_stall", int'(s_stall), 1);
        s_valid = 1'b0; s_hold = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
